// File: rtl/eq_band_scheduler.sv
// Time-multiplexed schedule for an equalizer bank: one shared MAC walks every tap of every band
// for each accepted sample. Strobes are decoded from the state and gated by ena.
module eq_band_scheduler #(
  parameter int N        = 16,
  parameter int NUM_FIRS = 8,
  parameter int NUM_TAPS = 16,
  localparam int TW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1,
  localparam int BW = (NUM_FIRS > 1) ? $clog2(NUM_FIRS) : 1,
  localparam int CW = $clog2(NUM_FIRS * NUM_TAPS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                sample_valid,
  input  logic signed [N-1:0] x_in,
  output logic                sample_ready,
  output logic                dl_wr,
  output logic [TW-1:0]       dl_wr_addr,
  output logic signed [N-1:0] dl_wr_data,
  output logic [TW-1:0]       dl_rd_addr,
  output logic [CW-1:0]       coef_addr,
  output logic                mac_clr,
  output logic                mac_en,
  output logic                band_wr,
  output logic [BW-1:0]       band_sel,
  output logic                out_valid,
  output logic                busy,
  output logic                overrun
);

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, MAC, WRITE, DONE} state_t;

  localparam logic [TW-1:0] TAP_LAST  = TW'(NUM_TAPS - 1);
  localparam logic [BW-1:0] BAND_LAST = BW'(NUM_FIRS - 1);

  state_t              state_q, state_d;
  logic [TW-1:0]       wp_q, wp_d;
  logic [TW-1:0]       base_q, base_d;
  logic [TW-1:0]       tap_q, tap_d;
  logic [BW-1:0]       band_q, band_d;
  logic signed [N-1:0] sample_q, sample_d;
  logic                overrun_q, overrun_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wp_q      <= '0;
      base_q    <= '0;
      tap_q     <= '0;
      band_q    <= '0;
      sample_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      base_q    <= base_d;
      tap_q     <= tap_d;
      band_q    <= band_d;
      sample_q  <= sample_d;
      overrun_q <= overrun_d;
    end
  end

  // With ena low every _d equals its _q and all strobes stay low, so a resume
  // re-enters the interrupted cycle exactly once.
  always_comb begin
    state_d   = state_q;
    wp_d      = wp_q;
    base_d    = base_q;
    tap_d     = tap_q;
    band_d    = band_q;
    sample_d  = sample_q;
    overrun_d = overrun_q;
    dl_wr     = 1'b0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    band_wr   = 1'b0;
    out_valid = 1'b0;
    if (ena) begin
      if (sample_valid && (state_q != IDLE)) overrun_d = 1'b1;
      case (state_q)
        IDLE: begin
          if (sample_valid) begin
            sample_d = x_in;
            state_d  = LOAD;
          end
        end
        LOAD: begin
          dl_wr   = 1'b1;
          base_d  = wp_q;
          wp_d    = wp_q + TW'(1);
          band_d  = '0;
          state_d = CLEAR;
        end
        CLEAR: begin
          mac_clr = 1'b1;
          tap_d   = '0;
          state_d = MAC;
        end
        MAC: begin
          mac_en = 1'b1;
          tap_d  = tap_q + TW'(1);
          if (tap_q == TAP_LAST) state_d = WRITE;
        end
        WRITE: begin
          band_wr = 1'b1;
          if (band_q == BAND_LAST) begin
            state_d = DONE;
          end else begin
            band_d  = band_q + BW'(1);
            state_d = CLEAR;
          end
        end
        DONE: begin
          out_valid = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Newest sample sits at base; tap k reads the sample k periods older.
  assign dl_wr_addr   = wp_q;
  assign dl_wr_data   = sample_q;
  assign dl_rd_addr   = base_q - tap_q;
  assign coef_addr    = CW'(band_q) * CW'(NUM_TAPS) + CW'(tap_q);
  assign band_sel     = band_q;
  assign sample_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;

endmodule
